// File: rtl/condicionador_botoes.sv
// rtl/condicionador_botoes.sv - synchronize, debounce and one-hot encode memory-game button presses
module condicionador_botoes #(
   parameter int N_BOTOES        = 4,
   parameter int DEBOUNCE_CICLOS = 50000,
   parameter int W_CNT           = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   input  logic [N_BOTOES-1:0] botoes_raw,
   output logic [N_BOTOES-1:0] botoes,
   output logic [N_BOTOES-1:0] jogada,
   output logic                tem_jogada,
   output logic                multipla,
   output logic [2:0]          db_estado
);

   typedef enum logic [2:0] {
      OCIOSO   = 3'd0,
      FILTRA   = 3'd1,
      ACEITO   = 3'd2,
      SEGURA   = 3'd3,
      SOLTA    = 3'd4,
      MULTIPLA = 3'd5
   } estado_t;

   localparam logic [W_CNT-1:0] CNT_FIM = W_CNT'(DEBOUNCE_CICLOS - 1);

   estado_t             r_estado;
   estado_t             w_prox;
   logic [N_BOTOES-1:0] r_sync1;
   logic [N_BOTOES-1:0] r_sync2;
   logic [N_BOTOES-1:0] r_cand;
   logic [N_BOTOES-1:0] w_cand_prox;
   logic [N_BOTOES-1:0] r_jogada;
   logic [N_BOTOES-1:0] w_jogada_prox;
   logic [W_CNT-1:0]    r_cnt;
   logic [W_CNT-1:0]    w_cnt_prox;
   logic                w_cnt_fim;
   logic                w_unico;
   logic                w_solto;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= botoes_raw;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_estado <= OCIOSO;
         r_cand   <= '0;
         r_cnt    <= '0;
         r_jogada <= '0;
      end else begin
         r_estado <= w_prox;
         r_cand   <= w_cand_prox;
         r_cnt    <= w_cnt_prox;
         r_jogada <= w_jogada_prox;
      end
   end

   assign w_cnt_fim = (r_cnt == CNT_FIM);
   assign w_unico   = ($countones(r_cand) == 1);
   assign w_solto   = (r_sync2 == '0);

   always_comb begin
      w_prox        = r_estado;
      w_cand_prox   = r_cand;
      w_cnt_prox    = r_cnt;
      w_jogada_prox = r_jogada;

      // The strobe has already been issued, so jogada follows it even if enable drops now
      if (r_estado == ACEITO) begin
         w_jogada_prox = r_cand;
      end

      if (!enable) begin
         w_prox     = SEGURA;
         w_cnt_prox = '0;
      end else begin
         case (r_estado)
            OCIOSO: begin
               if (!w_solto) begin
                  w_prox      = FILTRA;
                  w_cand_prox = r_sync2;
                  w_cnt_prox  = '0;
               end
            end
            FILTRA: begin
               if (w_solto) begin
                  w_prox = OCIOSO;
               end else if (r_sync2 != r_cand) begin
                  w_cand_prox = r_sync2;
                  w_cnt_prox  = '0;
               end else if (w_cnt_fim) begin
                  w_prox = w_unico ? ACEITO : MULTIPLA;
               end else begin
                  w_cnt_prox = r_cnt + 1'b1;
               end
            end
            ACEITO: begin
               w_prox = SEGURA;
            end
            SEGURA: begin
               if (w_solto) begin
                  w_prox     = SOLTA;
                  w_cnt_prox = '0;
               end
            end
            SOLTA: begin
               if (!w_solto) begin
                  w_prox = SEGURA;
               end else if (w_cnt_fim) begin
                  w_prox = OCIOSO;
               end else begin
                  w_cnt_prox = r_cnt + 1'b1;
               end
            end
            MULTIPLA: begin
               if (w_solto) begin
                  w_prox     = SOLTA;
                  w_cnt_prox = '0;
               end
            end
            default: begin
               w_prox = OCIOSO;
            end
         endcase
      end
   end

   assign botoes     = r_sync2;
   assign jogada     = r_jogada;
   assign tem_jogada = (r_estado == ACEITO);
   assign multipla   = (r_estado == MULTIPLA);
   assign db_estado  = r_estado;

endmodule

// File: tb/tb_condicionador_botoes.sv
// tb/tb_condicionador_botoes.sv - randomized and directed bench against a run-length reference model
module tb_condicionador_botoes;

   localparam int D  = 4;
   localparam int NB = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic [NB-1:0] botoes_raw = '0;
   logic [NB-1:0] botoes;
   logic [NB-1:0] jogada;
   logic          tem_jogada;
   logic          multipla;
   logic [2:0]    db_estado;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: sync delay line plus run lengths of equal samples
   logic [NB-1:0] m_q1, m_q2, m_cand, m_jog;
   bit            m_armed, m_strobe, m_multi;
   int            m_run, m_zrun;

   int dut_strobes;
   bit seen_multi;
   int ciclo_idx;
   int strobe_idx;

   condicionador_botoes #(
      .N_BOTOES(NB),
      .DEBOUNCE_CICLOS(D),
      .W_CNT(8)
   ) dut (
      .clock(clock),
      .reset(reset),
      .enable(enable),
      .botoes_raw(botoes_raw),
      .botoes(botoes),
      .jogada(jogada),
      .tem_jogada(tem_jogada),
      .multipla(multipla),
      .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q1 = '0; m_q2 = '0; m_cand = '0; m_jog = '0;
      m_armed = 1'b1; m_strobe = 1'b0; m_multi = 1'b0;
      m_run = 0; m_zrun = 0;
   endtask

   task automatic model_edge(input bit en, input logic [NB-1:0] raw);
      logic [NB-1:0] s;
      bit was_strobe;
      s = m_q2;
      m_q2 = m_q1;
      m_q1 = raw;
      was_strobe = m_strobe;
      if (m_strobe) begin
         m_jog = m_cand;
         m_strobe = 1'b0;
      end
      if (!en) begin
         m_armed = 1'b0; m_multi = 1'b0; m_zrun = 0; m_run = 0;
      end else if (was_strobe) begin
         m_zrun = 0; m_multi = 1'b0;
      end else if (m_armed) begin
         if (s == '0) begin
            m_run = 0;
         end else if (m_run > 0 && s == m_cand) begin
            m_run++;
            if (m_run == D + 1) begin
               m_armed = 1'b0;
               m_run = 0;
               m_zrun = 0;
               if ($countones(m_cand) == 1) m_strobe = 1'b1;
               else m_multi = 1'b1;
            end
         end else begin
            m_cand = s;
            m_run = 1;
         end
      end else begin
         if (s == '0) begin
            m_multi = 1'b0;
            m_zrun++;
            if (m_zrun == D + 1) begin
               m_armed = 1'b1;
               m_run = 0;
            end
         end else begin
            m_zrun = 0;
         end
      end
   endtask

   function automatic logic [2:0] m_estado();
      if (m_strobe) return 3'd2;
      if (m_armed) return (m_run > 0) ? 3'd1 : 3'd0;
      if (m_multi) return 3'd5;
      return (m_zrun > 0) ? 3'd4 : 3'd3;
   endfunction

   task automatic check_all();
      chk("botoes", 32'(botoes), 32'(m_q2));
      chk("jogada", 32'(jogada), 32'(m_jog));
      chk("tem_jogada", 32'(tem_jogada), 32'(m_strobe));
      chk("multipla", 32'(multipla), 32'(m_multi));
      chk("db_estado", 32'(db_estado), 32'(m_estado()));
      if (tem_jogada === 1'b1) begin
         dut_strobes++;
         strobe_idx = ciclo_idx;
      end
      if (multipla === 1'b1) seen_multi = 1'b1;
   endtask

   task automatic ciclo(input logic [NB-1:0] raw, input bit en);
      @(negedge clock);
      ciclo_idx++;
      check_all();
      botoes_raw = raw;
      enable = en;
      @(posedge clock);
      model_edge(en, raw);
   endtask

   task automatic segue(input logic [NB-1:0] raw, input bit en, input int n);
      for (int i = 0; i < n; i++) ciclo(raw, en);
   endtask

   task automatic inicia_teste();
      dut_strobes = 0;
      seen_multi = 1'b0;
      ciclo_idx = 0;
      strobe_idx = -1;
   endtask

   task automatic reset_async();
      @(negedge clock);
      #2 reset = 1'b0;
      #1;
      chk("rst_botoes", 32'(botoes), 32'h0);
      chk("rst_jogada", 32'(jogada), 32'h0);
      chk("rst_tem_jogada", 32'(tem_jogada), 32'h0);
      chk("rst_multipla", 32'(multipla), 32'h0);
      chk("rst_db_estado", 32'(db_estado), 32'h0);
      model_reset();
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      model_edge(enable, botoes_raw);
   endtask

   initial begin
      logic [NB-1:0] pat;
      int            len;
      model_reset();
      reset_async();
      inicia_teste();
      segue('0, 1'b1, 6);

      // Single press
      inicia_teste();
      segue(4'b0010, 1'b1, 20);
      chk("t1_strobe_edge", 32'(strobe_idx - 2), 32'(D + 2));
      segue(4'b0000, 1'b1, 10);
      chk("t1_strobes", 32'(dut_strobes), 32'd1);
      chk("t1_jogada", 32'(jogada), 32'b0010);
      chk("t1_idle", 32'(db_estado), 32'd0);

      // Bounce
      inicia_teste();
      for (int i = 0; i < 3; i++) begin
         segue(4'b0100, 1'b1, 2);
         segue(4'b0000, 1'b1, 2);
      end
      segue(4'b0100, 1'b1, 12);
      segue(4'b0000, 1'b1, 10);
      chk("t2_strobes", 32'(dut_strobes), 32'd1);
      chk("t2_jogada", 32'(jogada), 32'b0100);

      // Multiple buttons
      inicia_teste();
      segue(4'b0011, 1'b1, 10);
      chk("t3_multipla", 32'(seen_multi), 32'd1);
      segue(4'b0000, 1'b1, 10);
      chk("t3_strobes", 32'(dut_strobes), 32'd0);
      chk("t3_jogada", 32'(jogada), 32'b0100);
      chk("t3_idle", 32'(db_estado), 32'd0);

      // Enable gating
      inicia_teste();
      segue(4'b1000, 1'b0, 6);
      segue(4'b1000, 1'b1, 12);
      chk("t4_no_strobe", 32'(dut_strobes), 32'd0);
      segue(4'b0000, 1'b1, 10);
      segue(4'b1000, 1'b1, 12);
      segue(4'b0000, 1'b1, 10);
      chk("t4_strobes", 32'(dut_strobes), 32'd1);
      chk("t4_jogada", 32'(jogada), 32'b1000);

      // Reset mid-press, with FILTRA at cnt=2
      inicia_teste();
      segue(4'b0100, 1'b1, 5);
      @(negedge clock);
      chk("t5_filtra", 32'(db_estado), 32'd1);
      reset_async();
      inicia_teste();
      segue(4'b0100, 1'b1, 10);
      chk("t5_strobe_edge", 32'(strobe_idx - 1), 32'(D + 2));
      chk("t5_strobes", 32'(dut_strobes), 32'd1);
      chk("t5_jogada", 32'(jogada), 32'b0100);
      segue(4'b0000, 1'b1, 10);

      // Repeat press with a release shorter than the debounce
      inicia_teste();
      segue(4'b0001, 1'b1, 10);
      segue(4'b0000, 1'b1, 2);
      segue(4'b0001, 1'b1, 10);
      segue(4'b0000, 1'b1, 10);
      chk("t6_strobes", 32'(dut_strobes), 32'd1);
      chk("t6_jogada", 32'(jogada), 32'b0001);

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         case ($urandom_range(0, 3))
            0: pat = '0;
            1, 2: pat = NB'(1) << $urandom_range(0, NB - 1);
            default: pat = NB'($urandom);
         endcase
         len = $urandom_range(1, 9);
         if ($urandom_range(0, 59) == 0) reset_async();
         segue(pat, ($urandom_range(0, 9) != 0), len);
      end
      segue('0, 1'b1, 12);
      chk("final_idle", 32'(db_estado), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
